// File: rtl/exec_sequencer.sv
// Single-issue sequencer: accepts one instruction per 4 cycles, decodes it and walks STOP/FETCH/EXE/WRITE.
// All outputs registered; instr_ready is high only while idle in STOP.
module exec_sequencer #(
  parameter int DataSize   = 32,
  parameter int AddrSize   = 5,
  parameter int CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DataSize-1:0]   instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  alu_overflow,
  output logic [AddrSize-1:0]   read_address1,
  output logic [AddrSize-1:0]   read_address2,
  output logic [AddrSize-1:0]   write_address,
  output logic                  enable_fetch,
  output logic                  enable_execute,
  output logic                  enable_writeback,
  output logic [4:0]            imm_5bit,
  output logic [14:0]           imm_15bit,
  output logic [19:0]           imm_20bit,
  output logic [1:0]            mux4to1_select,
  output logic                  mux2to1_select,
  output logic                  imm_reg_select,
  output logic [5:0]            opcode,
  output logic [4:0]            sub_opcode,
  output logic                  instr_done,
  output logic                  illegal,
  output logic                  ovf_flag,
  output logic [CountWidth-1:0] retired_count
);

  typedef enum logic [1:0] {STOP, FETCH, EXE, WRITE} state_t;

  state_t state, state_nxt;
  logic   legal_q;
  logic   take;

  logic       dec_legal, dec_irs, dec_m2, dec_movi;
  logic [1:0] dec_m4;
  logic [5:0] dec_op;
  logic [4:0] dec_sub;

  assign take    = instr_valid && instr_ready;
  assign dec_op  = instr[30:25];
  assign dec_sub = instr[4:0];

  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (take) state_nxt = FETCH;
      FETCH:   state_nxt = EXE;
      EXE:     state_nxt = WRITE;
      WRITE:   state_nxt = STOP;
      default: state_nxt = STOP;
    endcase
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_irs   = 1'b0;
    dec_m2    = 1'b0;
    dec_m4    = 2'b00;
    dec_movi  = 1'b0;
    case (dec_op)
      6'b100000: begin
        case (dec_sub)
          5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100: dec_legal = 1'b1;
          5'b01000, 5'b01001, 5'b01011: begin
            dec_legal = 1'b1;
            dec_irs   = 1'b1;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'b100010: begin
        dec_legal = 1'b1;
        dec_irs   = 1'b1;
        dec_m4    = 2'b11;
        dec_m2    = 1'b1;
        dec_movi  = 1'b1;
      end
      6'b101000: begin
        dec_legal = 1'b1;
        dec_irs   = 1'b1;
        dec_m4    = 2'b01;
      end
      6'b101100, 6'b101011: begin
        dec_legal = 1'b1;
        dec_irs   = 1'b1;
        dec_m4    = 2'b10;
      end
      default: dec_legal = 1'b0;
    endcase
    // Illegal words keep raw fields visible but drive neutral selects.
    if (instr[31] || !dec_legal) begin
      dec_legal = 1'b0;
      dec_irs   = 1'b0;
      dec_m2    = 1'b0;
      dec_m4    = 2'b00;
      dec_movi  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= STOP;
      legal_q          <= 1'b0;
      instr_ready      <= 1'b0;
      enable_fetch     <= 1'b0;
      enable_execute   <= 1'b0;
      enable_writeback <= 1'b0;
      instr_done       <= 1'b0;
      read_address1    <= '0;
      read_address2    <= '0;
      write_address    <= '0;
      imm_5bit         <= '0;
      imm_15bit        <= '0;
      imm_20bit        <= '0;
      mux4to1_select   <= '0;
      mux2to1_select   <= 1'b0;
      imm_reg_select   <= 1'b0;
      opcode           <= '0;
      sub_opcode       <= '0;
      illegal          <= 1'b0;
      ovf_flag         <= 1'b0;
      retired_count    <= '0;
    end else begin
      state            <= state_nxt;
      instr_ready      <= (state_nxt == STOP);
      enable_fetch     <= (state_nxt == FETCH);
      enable_execute   <= (state_nxt == EXE);
      enable_writeback <= (state_nxt == WRITE) && legal_q;
      instr_done       <= (state_nxt == WRITE);
      if (take) begin
        legal_q        <= dec_legal;
        read_address1  <= dec_movi ? '0 : AddrSize'(instr[19:15]);
        read_address2  <= AddrSize'(instr[14:10]);
        write_address  <= AddrSize'(instr[24:20]);
        imm_5bit       <= instr[14:10];
        imm_15bit      <= instr[14:0];
        imm_20bit      <= instr[19:0];
        mux4to1_select <= dec_m4;
        mux2to1_select <= dec_m2;
        imm_reg_select <= dec_irs;
        opcode         <= dec_op;
        sub_opcode     <= dec_sub;
      end
      // Leaving EXE: retire/flag so the result is visible during WRITE.
      if (state == EXE) begin
        if (legal_q) begin
          retired_count <= retired_count + 1'b1;
          if (alu_overflow) ovf_flag <= 1'b1;
        end else begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed and randomized bench for exec_sequencer against a transaction-level reference model.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_overflow;
  logic [4:0]  read_address1, read_address2, write_address;
  logic        enable_fetch, enable_execute, enable_writeback;
  logic [4:0]  imm_5bit;
  logic [14:0] imm_15bit;
  logic [19:0] imm_20bit;
  logic [1:0]  mux4to1_select;
  logic        mux2to1_select, imm_reg_select;
  logic [5:0]  opcode;
  logic [4:0]  sub_opcode;
  logic        instr_done, illegal, ovf_flag;
  logic [15:0] retired_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_overflow(alu_overflow),
    .read_address1(read_address1), .read_address2(read_address2),
    .write_address(write_address), .enable_fetch(enable_fetch),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback),
    .imm_5bit(imm_5bit), .imm_15bit(imm_15bit), .imm_20bit(imm_20bit),
    .mux4to1_select(mux4to1_select), .mux2to1_select(mux2to1_select),
    .imm_reg_select(imm_reg_select), .opcode(opcode), .sub_opcode(sub_opcode),
    .instr_done(instr_done), .illegal(illegal), .ovf_flag(ovf_flag),
    .retired_count(retired_count)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: age counts cycles since acceptance (0 = idle, 3 = write).
  int          m_age;
  bit          m_rdy, m_legal, m_ill, m_ovf;
  logic [15:0] m_cnt;
  logic [69:0] m_dec;

  function automatic void ref_decode(input logic [31:0] w, output bit legal, output logic [69:0] dec);
    logic [5:0] op;
    logic [4:0] sub;
    bit is_alu, is_shift, movi, addi, logi;
    logic [1:0] m4;
    op       = w[30:25];
    sub      = w[4:0];
    is_alu   = (op == 6'h20) && (sub <= 5'd4);
    is_shift = (op == 6'h20) && (sub == 5'd8 || sub == 5'd9 || sub == 5'd11);
    movi     = (op == 6'h22);
    addi     = (op == 6'h28);
    logi     = (op == 6'h2c) || (op == 6'h2b);
    legal    = !w[31] && (is_alu || is_shift || movi || addi || logi);
    m4       = !legal ? 2'd0 : movi ? 2'd3 : addi ? 2'd1 : logi ? 2'd2 : 2'd0;
    dec = {(legal && movi) ? 5'd0 : w[19:15], w[14:10], w[24:20], w[14:10], w[14:0], w[19:0],
           m4, legal && movi, legal && !is_alu, op, sub};
  endfunction

  task automatic model_update();
    bit acc;
    if (rst) begin
      m_age = 0; m_rdy = 0; m_legal = 0; m_ill = 0; m_ovf = 0; m_cnt = '0; m_dec = '0;
    end else begin
      acc = instr_valid && m_rdy;
      if (m_age == 2) begin
        if (m_legal) begin
          m_cnt = m_cnt + 16'd1;
          if (alu_overflow) m_ovf = 1;
        end else begin
          m_ill = 1;
        end
      end
      if (acc) begin
        m_age = 1;
        ref_decode(instr, m_legal, m_dec);
      end else if (m_age != 0) begin
        m_age = (m_age + 1) % 4;
      end
      m_rdy = (m_age == 0);
    end
  endtask

  task automatic compare_all();
    logic [6:0] exp_ctrl;
    exp_ctrl = {m_rdy, m_age == 1, m_age == 2, (m_age == 3) && m_legal, m_age == 3, m_ill, m_ovf};
    check("ctrl", {89'd0, instr_ready, enable_fetch, enable_execute, enable_writeback,
                   instr_done, illegal, ovf_flag}, {89'd0, exp_ctrl});
    check("count", {80'd0, retired_count}, {80'd0, m_cnt});
    check("decode", {26'd0, read_address1, read_address2, write_address, imm_5bit, imm_15bit,
                     imm_20bit, mux4to1_select, mux2to1_select, imm_reg_select, opcode,
                     sub_opcode}, {26'd0, m_dec});
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] w, input bit o);
    rst = r; instr_valid = v; instr = w; alu_overflow = o;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] rand_word();
    int k;
    logic [31:0] w;
    logic [5:0] ops [5];
    logic [4:0] subs [8];
    ops  = '{6'h20, 6'h22, 6'h28, 6'h2c, 6'h2b};
    subs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd11};
    k = $urandom_range(0, 9);
    w = $urandom;
    if (k < 6) begin
      w[31]    = 1'b0;
      w[30:25] = ops[$urandom_range(0, 4)];
      if (w[30:25] == 6'h20) w[4:0] = subs[$urandom_range(0, 7)];
    end else if (k == 6) begin
      w = 32'h40000009;
    end else if (k == 7) begin
      w = 32'hFFFFFFFF;
    end
    return w;
  endfunction

  initial begin
    step(1, 0, 0, 0);
    step(1, 1, 32'h440000C8, 0);
    check("rst_ready", {95'd0, instr_ready}, 96'd0);
    check("rst_count", {80'd0, retired_count}, 96'd0);
    step(0, 0, 0, 0);
    check("ready_after_rst", {95'd0, instr_ready}, 96'd1);

    // MOVI r0,200
    step(0, 1, 32'h440000C8, 0);
    check("movi_ready", {95'd0, instr_ready}, 96'd0);
    check("movi_fetch", {93'd0, enable_fetch, enable_execute, enable_writeback}, 96'b100);
    check("movi_m4", {94'd0, mux4to1_select}, 96'd3);
    check("movi_m2", {95'd0, mux2to1_select}, 96'd1);
    check("movi_imm20", {76'd0, imm_20bit}, 96'd200);
    check("movi_rt", {91'd0, write_address}, 96'd0);
    step(0, 0, 0, 0);
    check("movi_exe", {93'd0, enable_fetch, enable_execute, enable_writeback}, 96'b010);
    step(0, 0, 0, 0);
    check("movi_wb", {93'd0, enable_fetch, enable_execute, enable_writeback}, 96'b001);
    step(0, 0, 0, 0);
    check("movi_retired", {80'd0, retired_count}, 96'd1);

    // ADDI then ADD with valid held high
    step(0, 1, 32'h50100064, 0);
    check("addi_m4", {94'd0, mux4to1_select}, 96'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h40200400, 0);
      check("held_no_accept", {95'd0, enable_fetch}, 96'd0);
    end
    step(0, 1, 32'h40200400, 0);
    check("add_accept_4", {95'd0, enable_fetch}, 96'd1);
    check("add_rb", {91'd0, read_address2}, 96'd1);
    check("add_irs", {95'd0, imm_reg_select}, 96'd0);
    check("add_sub", {91'd0, sub_opcode}, 96'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("add_retired", {80'd0, retired_count}, 96'd3);
    check("add_ovf", {95'd0, ovf_flag}, 96'd1);

    // ORI / XORI / SRLI decode
    step(0, 1, 32'h58200064, 0);
    check("ori_m4", {94'd0, mux4to1_select}, 96'd2);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 32'h56200064, 0);
    check("xori_op", {90'd0, opcode}, 96'h2b);
    check("xori_m4", {94'd0, mux4to1_select}, 96'd2);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 32'h40000C09, 0);
    check("srli_imm5", {91'd0, imm_5bit}, 96'd3);
    check("srli_irs", {95'd0, imm_reg_select}, 96'd1);
    repeat (3) step(0, 0, 0, 0);
    check("ovf_sticky", {95'd0, ovf_flag}, 96'd1);

    // Illegal word
    step(0, 1, 32'hFFFFFFFF, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("ill_wb", {95'd0, enable_writeback}, 96'd0);
    check("ill_done", {95'd0, instr_done}, 96'd1);
    check("ill_flag", {95'd0, illegal}, 96'd1);
    check("ill_count", {80'd0, retired_count}, 96'd6);
    step(0, 0, 0, 0);

    // rst during EXE
    step(0, 1, 32'h40200400, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_exe_en", {93'd0, enable_fetch, enable_execute, enable_writeback}, 96'd0);
    check("rst_exe_cnt", {80'd0, retired_count}, 96'd0);
    check("rst_exe_ovf", {95'd0, ovf_flag}, 96'd0);
    step(0, 0, 0, 0);
    check("rst_exe_ready", {95'd0, instr_ready}, 96'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), rand_word(), ($urandom_range(0, 2) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
